// File: rtl/mixpix_readout_seq.sv
// mixpix_readout_seq
// Readout sequencer for the mixed-signal pixel macro. Walks the enabled
// photodiodes one at a time through reset, integrate, hold and compare
// phases, measures the integration cycle at which the comparator first
// trips, and presents one result word per channel on a valid/ready port.
// All macro controls are registered so the pins never glitch; the next
// register value is decoded from the next FSM state.
module mixpix_readout_seq #(
    parameter int NUM_PD = 12,
    parameter int CNT_W  = 16,
    parameter int T_RST  = 8,
    parameter int T_SH   = 4,
    parameter int T_CMP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [CNT_W-1:0]  int_time,
    input  logic [NUM_PD-1:0] ch_mask,
    input  logic              cmp_in,
    output logic              sh_rst,
    output logic              sh,
    output logic              sh_cmp,
    output logic              sw1,
    output logic              sw2,
    output logic [NUM_PD-1:0] pd_a,
    output logic [NUM_PD-1:0] pd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [3:0]        res_ch,
    output logic [1:0]        res_flag,
    output logic              busy,
    output logic              frame_done
);

    // Pointer is one bit wider than a channel index so it can reach NUM_PD,
    // which marks the end of the frame.
    localparam int PTR_W = 5;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONES = {CNT_W{1'b1}};
    localparam logic [NUM_PD-1:0] PD_ZERO  = {NUM_PD{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_END  = PTR_W'(NUM_PD);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SEL  = 4'd1,
        RST  = 4'd2,
        G1   = 4'd3,
        INT  = 4'd4,
        G2   = 4'd5,
        HOLD = 4'd6,
        G3   = 4'd7,
        CMP  = 4'd8,
        OUT  = 4'd9
    } state_t;

    // One-hot photodiode select for a channel index; indices past the
    // array decode to all-zero so no diode can be selected by accident.
    function automatic logic [NUM_PD-1:0] pd_decode(input logic [PTR_W-1:0] idx);
        pd_decode = NUM_PD'(1'b1) << idx;
    endfunction

    // True on the last cycle of a fixed-length phase.
    function automatic logic phase_end(input logic [CNT_W-1:0] cnt, input int len);
        phase_end = (cnt == CNT_W'(len - 32'sd1));
    endfunction

    state_t             state_r, state_nxt_s;
    logic [PTR_W-1:0]   ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]   len_r, len_nxt_s;
    logic [NUM_PD-1:0]  mask_r, mask_nxt_s;
    logic [CNT_W-1:0]   lat_r, lat_nxt_s;
    logic               crossed_r, crossed_nxt_s;
    logic               final_r, final_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_nxt_s;
    logic [NUM_PD-1:0]  sel_bits_s;

    logic               cmp_meta_r, cmp_sync_r, cmp_s;

    logic               sh_rst_r, sh_r, sh_cmp_r, sw1_r, sw2_r;
    logic [NUM_PD-1:0]  pd_a_r, pd_b_r;
    logic               res_valid_r, done_r;
    logic [CNT_W-1:0]   res_count_r;
    logic [3:0]         res_ch_r;
    logic [1:0]         res_flag_r;

    logic               sh_rst_nxt_s, sh_nxt_s, sh_cmp_nxt_s, sw1_nxt_s, sw2_nxt_s;
    logic [NUM_PD-1:0]  pd_a_nxt_s, pd_b_nxt_s;
    logic               res_valid_nxt_s;
    logic [CNT_W-1:0]   res_count_nxt_s;
    logic [3:0]         res_ch_nxt_s;
    logic [1:0]         res_flag_nxt_s;

    assign cmp_s      = cmp_sync_r;
    assign sel_bits_s = mask_r >> ptr_r;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta_r <= 1'b0;
            cmp_sync_r <= 1'b0;
        end else begin
            cmp_meta_r <= cmp_in;
            cmp_sync_r <= cmp_meta_r;
        end
    end

    // FSM state and per-channel datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= PTR_ZERO;
            cnt_r     <= CNT_ZERO;
            len_r     <= CNT_ONE;
            mask_r    <= PD_ZERO;
            lat_r     <= CNT_ZERO;
            crossed_r <= 1'b0;
            final_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            len_r     <= len_nxt_s;
            mask_r    <= mask_nxt_s;
            lat_r     <= lat_nxt_s;
            crossed_r <= crossed_nxt_s;
            final_r   <= final_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Next-state and datapath decode; every phase restarts the phase counter.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        len_nxt_s     = len_r;
        mask_nxt_s    = mask_r;
        lat_nxt_s     = lat_r;
        crossed_nxt_s = crossed_r;
        final_nxt_s   = final_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SEL;
                    ptr_nxt_s   = PTR_ZERO;
                    mask_nxt_s  = ch_mask;
                    busy_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            SEL: begin
                if (ptr_r >= PTR_END) begin
                    // End of frame: either rescan from channel 0 or stop.
                    done_nxt_s = 1'b1;
                    ptr_nxt_s  = PTR_ZERO;
                    if (cont) begin
                        state_nxt_s = SEL;
                        mask_nxt_s  = ch_mask;
                    end else begin
                        state_nxt_s = IDLE;
                        busy_nxt_s  = 1'b0;
                    end
                end else if (sel_bits_s[0]) begin
                    state_nxt_s   = RST;
                    cnt_nxt_s     = CNT_ZERO;
                    lat_nxt_s     = CNT_ZERO;
                    crossed_nxt_s = 1'b0;
                    final_nxt_s   = 1'b0;
                end else begin
                    ptr_nxt_s = ptr_r + PTR_ONE;
                end
            end
            RST: begin
                if (phase_end(cnt_r, T_RST)) begin
                    state_nxt_s = G1;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            G1: begin
                state_nxt_s = INT;
                cnt_nxt_s   = CNT_ZERO;
                len_nxt_s   = (int_time == CNT_ZERO) ? CNT_ONE : int_time;
            end
            INT: begin
                // Only the first trip is recorded; INT always runs to length.
                if (!crossed_r && cmp_s) begin
                    crossed_nxt_s = 1'b1;
                    lat_nxt_s     = cnt_r;
                end else begin
                    crossed_nxt_s = crossed_r;
                    lat_nxt_s     = lat_r;
                end
                if (cnt_r == (len_r - CNT_ONE)) begin
                    state_nxt_s = G2;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            G2: begin
                state_nxt_s = HOLD;
                cnt_nxt_s   = CNT_ZERO;
            end
            HOLD: begin
                if (phase_end(cnt_r, T_SH)) begin
                    state_nxt_s = G3;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            G3: begin
                state_nxt_s = CMP;
                cnt_nxt_s   = CNT_ZERO;
            end
            CMP: begin
                if (phase_end(cnt_r, T_CMP)) begin
                    state_nxt_s = OUT;
                    cnt_nxt_s   = CNT_ZERO;
                    final_nxt_s = cmp_s;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_nxt_s = SEL;
                    ptr_nxt_s   = ptr_r + PTR_ONE;
                    mask_nxt_s  = ch_mask;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = PTR_ZERO;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered pins line up with the state.
    always_comb begin
        sh_rst_nxt_s    = 1'b0;
        sh_nxt_s        = 1'b0;
        sh_cmp_nxt_s    = 1'b0;
        sw1_nxt_s       = 1'b0;
        sw2_nxt_s       = 1'b0;
        pd_a_nxt_s      = PD_ZERO;
        pd_b_nxt_s      = PD_ZERO;
        res_valid_nxt_s = 1'b0;
        res_count_nxt_s = CNT_ZERO;
        res_ch_nxt_s    = 4'd0;
        res_flag_nxt_s  = 2'b00;
        case (state_nxt_s)
            RST: begin
                sh_rst_nxt_s = 1'b1;
                pd_b_nxt_s   = pd_decode(ptr_nxt_s);
            end
            INT: begin
                sw1_nxt_s  = 1'b1;
                pd_a_nxt_s = pd_decode(ptr_nxt_s);
            end
            HOLD: begin
                sh_nxt_s   = 1'b1;
                pd_a_nxt_s = pd_decode(ptr_nxt_s);
            end
            CMP: begin
                sh_cmp_nxt_s = 1'b1;
                sw2_nxt_s    = 1'b1;
            end
            OUT: begin
                res_valid_nxt_s = 1'b1;
                res_count_nxt_s = crossed_nxt_s ? lat_nxt_s : CNT_ONES;
                res_ch_nxt_s    = ptr_nxt_s[3:0];
                res_flag_nxt_s  = {final_nxt_s, crossed_nxt_s};
            end
            default: begin
                sh_rst_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; asynchronous reset drops every pin at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_rst_r    <= 1'b0;
            sh_r        <= 1'b0;
            sh_cmp_r    <= 1'b0;
            sw1_r       <= 1'b0;
            sw2_r       <= 1'b0;
            pd_a_r      <= PD_ZERO;
            pd_b_r      <= PD_ZERO;
            res_valid_r <= 1'b0;
            res_count_r <= CNT_ZERO;
            res_ch_r    <= 4'd0;
            res_flag_r  <= 2'b00;
            done_r      <= 1'b0;
        end else begin
            sh_rst_r    <= sh_rst_nxt_s;
            sh_r        <= sh_nxt_s;
            sh_cmp_r    <= sh_cmp_nxt_s;
            sw1_r       <= sw1_nxt_s;
            sw2_r       <= sw2_nxt_s;
            pd_a_r      <= pd_a_nxt_s;
            pd_b_r      <= pd_b_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            res_count_r <= res_count_nxt_s;
            res_ch_r    <= res_ch_nxt_s;
            res_flag_r  <= res_flag_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign sh_rst     = sh_rst_r;
    assign sh         = sh_r;
    assign sh_cmp     = sh_cmp_r;
    assign sw1        = sw1_r;
    assign sw2        = sw2_r;
    assign pd_a       = pd_a_r;
    assign pd_b       = pd_b_r;
    assign res_valid  = res_valid_r;
    assign res_count  = res_count_r;
    assign res_ch     = res_ch_r;
    assign res_flag   = res_flag_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule
